otter_io_hub: RTL and testbench



---
 rtl/otter_io_hub.sv | 166 ++++++++++++++++
 tb/tb_otter_io_hub.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/otter_io_hub.sv
// OTTER IOBUS peripheral: switch/button inputs with debounce and sticky events,
// LED and seven-segment outputs, all behind a relocatable register block.
module otter_io_hub #(
    parameter logic [31:0] BASE_ADDR       = 32'h1100_0000,
    parameter int          N_SW            = 16,
    parameter int          N_BTN           = 5,
    parameter int          N_LED           = 16,
    parameter int          DIGITS          = 4,
    parameter int          DEBOUNCE_CYCLES = 250000,
    parameter int          SCAN_DIV        = 100000
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [31:0]       IOBUS_ADDR,
    input  logic [31:0]       IOBUS_OUT,
    input  logic              IOBUS_WR,
    output logic [31:0]       IOBUS_IN,
    input  logic [N_SW-1:0]   SWITCHES,
    input  logic [N_BTN-1:0]  BUTTONS,
    output logic [N_LED-1:0]  LEDS,
    output logic [7:0]        SEGS,
    output logic [DIGITS-1:0] AN,
    output logic              INTR
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [N_SW-1:0]            r_sw_s1, r_sw_s2;
    logic [N_BTN-1:0]           r_btn_s1, r_btn_s2, r_btn, r_evt, r_irq_en;
    logic [N_BTN-1:0][CW-1:0]   r_db_cnt;
    logic [N_BTN-1:0]           w_tgl, w_rise;
    logic [N_LED-1:0]           r_led;
    logic [4*DIGITS-1:0]        r_hex;
    logic                       r_en;
    logic [DIGITS-1:0]          r_blank, r_dp;
    logic [PW-1:0]              r_pre;
    logic [DW-1:0]              r_dig;
    logic [DIGITS-1:0]          r_an;
    logic [7:0]                 r_segs;
    logic                       r_intr;
    logic [31:0]                w_off, w_rd;
    logic [3:0]                 w_nib;
    logic                       w_wr_evt, w_wr_irq, w_wr_led, w_wr_hex, w_wr_sctl;

    function automatic logic [6:0] hexfont(input logic [3:0] n);
        case (n)
            4'h0: hexfont = 7'h40; 4'h1: hexfont = 7'h79; 4'h2: hexfont = 7'h24; 4'h3: hexfont = 7'h30;
            4'h4: hexfont = 7'h19; 4'h5: hexfont = 7'h12; 4'h6: hexfont = 7'h02; 4'h7: hexfont = 7'h78;
            4'h8: hexfont = 7'h00; 4'h9: hexfont = 7'h10; 4'hA: hexfont = 7'h08; 4'hB: hexfont = 7'h03;
            4'hC: hexfont = 7'h46; 4'hD: hexfont = 7'h21; 4'hE: hexfont = 7'h06; default: hexfont = 7'h0E;
        endcase
    endfunction

    assign w_off     = IOBUS_ADDR - BASE_ADDR;
    assign w_wr_evt  = IOBUS_WR && (w_off == 32'h08);
    assign w_wr_irq  = IOBUS_WR && (w_off == 32'h0C);
    assign w_wr_led  = IOBUS_WR && (w_off == 32'h20);
    assign w_wr_hex  = IOBUS_WR && (w_off == 32'h24);
    assign w_wr_sctl = IOBUS_WR && (w_off == 32'h28);

    // A button toggles on the last mismatching sample; a rise is a toggle from 0.
    always_comb begin
        w_tgl = '0;
        for (int i = 0; i < N_BTN; i++)
            w_tgl[i] = (r_btn_s2[i] != r_btn[i]) && (r_db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
        w_rise = w_tgl & ~r_btn;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
            r_btn    <= '0;
            r_db_cnt <= '0;
        end else begin
            r_sw_s1  <= SWITCHES;
            r_sw_s2  <= r_sw_s1;
            r_btn_s1 <= BUTTONS;
            r_btn_s2 <= r_btn_s1;
            for (int i = 0; i < N_BTN; i++) begin
                if (r_btn_s2[i] == r_btn[i] || w_tgl[i])
                    r_db_cnt[i] <= '0;
                else
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
            end
            r_btn <= r_btn ^ w_tgl;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_evt    <= '0;
            r_irq_en <= '0;
            r_led    <= '0;
            r_hex    <= '0;
            r_en     <= 1'b0;
            r_blank  <= '0;
            r_dp     <= '0;
            r_intr   <= 1'b0;
        end else begin
            // Set after clear so a same-cycle new edge survives the W1C.
            r_evt  <= (r_evt & ~(w_wr_evt ? IOBUS_OUT[N_BTN-1:0] : '0)) | w_rise;
            r_intr <= |(r_evt & r_irq_en);
            if (w_wr_irq) r_irq_en <= IOBUS_OUT[N_BTN-1:0];
            if (w_wr_led) r_led    <= IOBUS_OUT[N_LED-1:0];
            if (w_wr_hex) r_hex    <= IOBUS_OUT[4*DIGITS-1:0];
            if (w_wr_sctl) begin
                r_en    <= IOBUS_OUT[0];
                r_blank <= IOBUS_OUT[8 +: DIGITS];
                r_dp    <= IOBUS_OUT[16 +: DIGITS];
            end
        end
    end

    assign w_nib = r_hex[4*int'(r_dig) +: 4];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pre  <= '0;
            r_dig  <= '0;
            r_an   <= '1;
            r_segs <= 8'hFF;
        end else begin
            if (r_pre == PW'(SCAN_DIV - 1)) begin
                r_pre <= '0;
                r_dig <= (r_dig == DW'(DIGITS - 1)) ? '0 : r_dig + 1'b1;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
            if (r_en && !r_blank[r_dig]) begin
                r_an   <= ~(DIGITS'(1) << r_dig);
                r_segs <= {~r_dp[r_dig], hexfont(w_nib)};
            end else begin
                r_an   <= '1;
                r_segs <= 8'hFF;
            end
        end
    end

    always_comb begin
        w_rd = '0;
        case (w_off)
            32'h00: w_rd[N_SW-1:0]  = r_sw_s2;
            32'h04: w_rd[N_BTN-1:0] = r_btn;
            32'h08: w_rd[N_BTN-1:0] = r_evt;
            32'h0C: w_rd[N_BTN-1:0] = r_irq_en;
            32'h20: w_rd[N_LED-1:0] = r_led;
            32'h24: w_rd[4*DIGITS-1:0] = r_hex;
            32'h28: begin
                w_rd[0]           = r_en;
                w_rd[8 +: DIGITS]  = r_blank;
                w_rd[16 +: DIGITS] = r_dp;
            end
            default: w_rd = '0;
        endcase
    end

    assign IOBUS_IN = w_rd;
    assign LEDS     = r_led;
    assign SEGS     = r_segs;
    assign AN       = r_an;
    assign INTR     = r_intr;
endmodule

// File: tb/tb_otter_io_hub.sv
// Directed-vector bench for otter_io_hub with short debounce and scan periods.
module tb_otter_io_hub;
    localparam logic [31:0] BA = 32'h1100_0000;

    logic        CLK = 1'b0, RST_N = 1'b0;
    logic [31:0] IOBUS_ADDR = '0, IOBUS_OUT = '0, IOBUS_IN;
    logic        IOBUS_WR = 1'b0;
    logic [15:0] SWITCHES = '0, LEDS;
    logic [4:0]  BUTTONS = '0;
    logic [7:0]  SEGS;
    logic [3:0]  AN;
    logic        INTR;

    int checks = 0, errors = 0;

    otter_io_hub #(.BASE_ADDR(BA), .DEBOUNCE_CYCLES(4), .SCAN_DIV(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
        .IOBUS_WR(IOBUS_WR), .IOBUS_IN(IOBUS_IN), .SWITCHES(SWITCHES), .BUTTONS(BUTTONS),
        .LEDS(LEDS), .SEGS(SEGS), .AN(AN), .INTR(INTR));

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        IOBUS_ADDR = BA + off;
        IOBUS_OUT  = d;
        IOBUS_WR   = 1'b1;
        tick();
        IOBUS_WR   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] off, input logic [31:0] exp);
        IOBUS_ADDR = BA + off;
        #1;
        check(tag, IOBUS_IN, exp);
    endtask

    // Align to the first cycle digit 0 is shown: wait for digit 3, then for it to end.
    task automatic sync_digit0(input string tag);
        for (int i = 0; i < 100 && AN !== 4'h7; i++) tick();
        for (int i = 0; i < 20 && AN === 4'h7; i++) tick();
        check(tag, {28'h0, AN}, 32'hE);
    endtask

    initial begin
        logic [3:0] an_exp [4];
        logic [7:0] sg_exp [4];

        #12;
        rd("rst_sw", 32'h00, 0);   rd("rst_btn", 32'h04, 0); rd("rst_evt", 32'h08, 0);
        rd("rst_irq", 32'h0C, 0);  rd("rst_led", 32'h20, 0); rd("rst_hex", 32'h24, 0);
        rd("rst_sctl", 32'h28, 0);
        check("rst_segs", {24'h0, SEGS}, 32'hFF);
        check("rst_an", {28'h0, AN}, 32'hF);
        check("rst_intr", {31'h0, INTR}, 0);
        RST_N = 1'b1;
        tick();

        wr(32'h20, 32'h0000_A5A5);
        rd("led_rb", 32'h20, 32'h0000_A5A5);
        check("leds_pin", {16'h0, LEDS}, 32'hA5A5);
        wr(32'h00, 32'h0000_FFFF);
        rd("sw_ro", 32'h00, 0);
        rd("unmapped", 32'h30, 0);
        IOBUS_ADDR = 32'h2100_0020; #1;
        check("full_decode", IOBUS_IN, 0);

        SWITCHES = 16'h1234;
        tick();
        rd("sw_lat1", 32'h00, 0);
        tick();
        rd("sw_lat2", 32'h00, 32'h1234);

        BUTTONS[0] = 1'b1;
        tick(3);
        BUTTONS[0] = 1'b0;
        tick(10);
        rd("glitch_btn", 32'h04, 0);
        rd("glitch_evt", 32'h08, 0);

        wr(32'h0C, 32'h04);
        rd("irq_rb", 32'h0C, 32'h04);
        BUTTONS[2] = 1'b1;
        tick(5);
        rd("btn_c5", 32'h04, 0);
        tick();
        rd("btn_c6", 32'h04, 32'h04);
        rd("evt_c6", 32'h08, 32'h04);
        check("intr_c6", {31'h0, INTR}, 0);
        tick();
        check("intr_c7", {31'h0, INTR}, 1);
        wr(32'h08, 32'h04);
        rd("evt_w1c", 32'h08, 0);
        tick();
        check("intr_clr", {31'h0, INTR}, 0);

        BUTTONS[2] = 1'b0;
        tick(10);
        rd("btn_rel", 32'h04, 0);
        rd("evt_rel", 32'h08, 0);
        BUTTONS[2] = 1'b1;
        tick(5);
        wr(32'h08, 32'h04);
        rd("set_wins_btn", 32'h04, 32'h04);
        rd("set_wins_evt", 32'h08, 32'h04);

        wr(32'h24, 32'h0000_12AF);
        wr(32'h28, 32'h0000_0001);
        rd("hex_rb", 32'h24, 32'h12AF);
        an_exp = '{4'hE, 4'hD, 4'hB, 4'h7};
        sg_exp = '{8'h8E, 8'h88, 8'hA4, 8'hF9};
        sync_digit0("scan_sync");
        for (int k = 0; k < 4; k++) begin
            check($sformatf("scan_an%0d", k), {28'h0, AN}, {28'h0, an_exp[k]});
            check($sformatf("scan_seg%0d", k), {24'h0, SEGS}, {24'h0, sg_exp[k]});
            tick(7);
            check($sformatf("scan_hold%0d", k), {28'h0, AN}, {28'h0, an_exp[k]});
            tick();
        end

        wr(32'h28, 32'h0002_0201);
        rd("sctl_rb", 32'h28, 32'h0002_0201);
        an_exp = '{4'hE, 4'hF, 4'hB, 4'h7};
        sg_exp = '{8'h8E, 8'hFF, 8'hA4, 8'hF9};
        sync_digit0("blank_sync");
        for (int k = 0; k < 4; k++) begin
            check($sformatf("blank_an%0d", k), {28'h0, AN}, {28'h0, an_exp[k]});
            check($sformatf("blank_seg%0d", k), {24'h0, SEGS}, {24'h0, sg_exp[k]});
            tick(8);
        end

        tick(3);
        IOBUS_ADDR = BA + 32'h20;
        IOBUS_OUT  = 32'h0000_FFFF;
        IOBUS_WR   = 1'b1;
        #2 RST_N = 1'b0;
        #1;
        check("arst_leds", {16'h0, LEDS}, 0);
        check("arst_an", {28'h0, AN}, 32'hF);
        check("arst_segs", {24'h0, SEGS}, 32'hFF);
        check("arst_intr", {31'h0, INTR}, 0);
        tick();
        IOBUS_WR = 1'b0;
        RST_N = 1'b1;
        tick();
        rd("arst_wr_lost", 32'h20, 0);
        rd("arst_evt", 32'h08, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
